// File: rtl/budget_regulator.sv
// rtl/budget_regulator.sv - per-queue budget regulation and round-robin grant for a shared serializer
//
// Purpose: arbitrates between NUMBER_OF_QUEUES packet queues feeding one serializer.
//          Each queue may issue at most budgets[i] packets per regulation period.
//          A period of 0 turns regulation off and leaves plain round-robin.
//
// Ports:
//   clock           - single clock, rising edge
//   reset           - asynchronous, active-high
//   empty           - per-queue empty flag (1 = no packet)
//   budgets         - per-queue packet allowance per period
//   period          - period length in cycles, 0 disables regulation
//   consumed        - serializer has taken the granted packet
//   id              - index of the granted queue
//   enable          - grant outstanding
//   hasBeenConsumed - one-hot pop pulse to the queues
//   exhausted       - per-queue "no budget left" while regulating
//   period_tick     - one-cycle pulse in the cycle whose closing edge reloads budgets

module budget_regulator #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   budgets,
    input  logic [REGISTER_SIZE-1:0]                         period,
    input  logic                                             consumed,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              id,
    output logic                                             enable,
    output logic [NUMBER_OF_QUEUES-1:0]                      hasBeenConsumed,
    output logic [NUMBER_OF_QUEUES-1:0]                      exhausted,
    output logic                                             period_tick
);

    localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RETIRE = 2'd2
    } state_t;

    state_t                                         state;
    state_t                                         next_state;

    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] remaining;
    logic [REGISTER_SIZE-1:0]                       period_count;
    logic                                           reload_pending;
    logic [ID_W-1:0]                                last_granted;

    logic                                           regulate;
    logic                                           wrap;
    logic [NUMBER_OF_QUEUES-1:0]                    eligible;
    logic                                           grant_found;
    logic [ID_W-1:0]                                grant_idx;
    logic [ID_W-1:0]                                cand;

    assign regulate = (period != '0);
    assign wrap     = regulate && (period_count == period - REGISTER_SIZE'(1));

    // Gated with reset so a period of 1 cannot produce a tick while held in reset.
    assign period_tick = wrap && !reset;

    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            eligible[i]  = !empty[i] && (!regulate || (remaining[i] != '0));
            exhausted[i] = regulate && (remaining[i] == '0);
        end
    end

    // Round-robin search starting just after the last retired grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUMBER_OF_QUEUES; k++) begin
            cand = ID_W'((int'(last_granted) + k) % NUMBER_OF_QUEUES);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = WAIT;
            WAIT:    if (consumed)    next_state = RETIRE;
            RETIRE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs. Decoding from state lets an asynchronous reset drop enable at once.
    always_comb begin
        enable          = (state == WAIT);
        hasBeenConsumed = '0;
        if (state == RETIRE) begin
            hasBeenConsumed[id] = 1'b1;
        end
    end

    // Budget bookkeeping and grant registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_count   <= '0;
            reload_pending <= 1'b1;
            remaining      <= '0;
            id             <= '0;
            last_granted   <= ID_W'(NUMBER_OF_QUEUES - 1);
        end else begin
            if (!regulate) begin
                period_count <= '0;
            end else if (wrap) begin
                period_count <= '0;
            end else begin
                period_count <= period_count + REGISTER_SIZE'(1);
            end

            reload_pending <= 1'b0;

            // A reload takes priority over a retire decrement in the same cycle.
            if (reload_pending || wrap) begin
                remaining <= budgets;
            end else if ((state == RETIRE) && regulate && (remaining[id] != '0)) begin
                remaining[id] <= remaining[id] - REGISTER_SIZE'(1);
            end

            if ((state == IDLE) && grant_found) begin
                id <= grant_idx;
            end

            if (state == RETIRE) begin
                last_granted <= id;
            end
        end
    end

endmodule
